// File: rtl/mm_vmx_pkg.sv
// mm_vmx_pkg: shared defaults (DEF_DW, DEF_COLS, DEF_DEPTH) and the sequencer FSM state type
package mm_vmx_pkg;
  localparam int DEF_DW = 32;
  localparam int DEF_COLS = 4;
  localparam int DEF_DEPTH = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/psum_fifo.sv
// psum_fifo: first-word-fall-through row FIFO; ports clk/rst (async high), i_push/i_data write, i_pop/o_data/o_valid read (o_data 0 when empty), o_count occupancy
module psum_fifo #(
  parameter int W = 128,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_pop;
  assign o_valid = r_count != '0;
  assign w_pop = i_pop && o_valid;
  assign o_data = o_valid ? r_mem[r_rd] : '0;
  assign o_count = r_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr == AW'(DEPTH-1) ? '0 : r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd == AW'(DEPTH-1) ? '0 : r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr] <= i_data;
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && r_count == CW'(DEPTH)))
    else $error("psum_fifo push while full");
endmodule

// File: rtl/psum_sequencer.sv
// psum_sequencer: issues skewed bias rows to the collector chain and deskews captured sums into a result FIFO; ports start/tile_len/busy/done control, bin_* bias in, en_out/bin_col/sout_col collector side, res_* result out
module psum_sequencer
  import mm_vmx_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int DW = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          tile_len,
  input  logic                 bin_valid,
  output logic                 bin_ready,
  input  logic [COLS*DW-1:0]   bin_data,
  output logic                 en_out,
  output logic [COLS*DW-1:0]   bin_col,
  input  logic [COLS*DW-1:0]   sout_col,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [COLS*DW-1:0]   res_data,
  output logic                 busy,
  output logic                 done
);
  localparam int W = COLS*DW;
  localparam int CW = $clog2(DEPTH+1);
  state_t r_state, w_next;
  logic [15:0] r_len, r_issued;
  logic [CW-1:0] r_inflight, w_count;
  logic [COLS-1:0] r_v;
  logic [W-1:0] r_bias [COLS];
  logic [W-1:0] r_asm [COLS-1];
  logic [W-1:0] w_row [COLS];
  logic w_issue, w_push;
  assign w_issue = bin_valid && bin_ready;
  assign w_push = r_v[COLS-1];
  assign en_out = r_v[0];
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE  ? (start ? RUN : IDLE) :
             r_state == RUN   ? (r_issued == r_len ? DRAIN : RUN) :
             r_state == DRAIN ? (r_inflight == '0 && w_count == '0 ? DONE : DRAIN) :
                                IDLE;
  always_comb begin
    busy = r_state != IDLE;
    done = r_state == DONE;
    bin_ready = r_state == RUN && r_issued < r_len && ({1'b0, r_inflight} + {1'b0, w_count}) < (CW+1)'(DEPTH);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_len <= '0;
      r_issued <= '0;
      r_inflight <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_len <= tile_len;
        r_issued <= '0;
      end else if (w_issue) r_issued <= r_issued + 1'b1;
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_v <= '0;
      for (int j = 0; j < COLS; j++) r_bias[j] <= '0;
    end else begin
      r_v <= {r_v[COLS-2:0], w_issue};
      r_bias[0] <= w_issue ? bin_data : '0;
      for (int j = 1; j < COLS; j++) r_bias[j] <= r_bias[j-1];
    end
  always_ff @(posedge clk)
    for (int j = 0; j < COLS-1; j++) r_asm[j] <= w_row[j];
  always_comb begin
    w_row[0] = '0;
    w_row[0][DW-1:0] = sout_col[DW-1:0];
    for (int j = 1; j < COLS; j++) begin
      w_row[j] = r_asm[j-1];
      w_row[j][j*DW+:DW] = sout_col[j*DW+:DW];
    end
  end
  always_comb begin
    bin_col = '0;
    for (int k = 0; k < COLS; k++) bin_col[k*DW+:DW] = r_bias[k][k*DW+:DW];
  end
  psum_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(w_push),
    .i_data(w_row[COLS-1]),
    .i_pop(res_ready),
    .o_data(res_data),
    .o_valid(res_valid),
    .o_count(w_count)
  );
endmodule

// File: tb/tb_psum_sequencer.sv
// tb_psum_sequencer: directed stimulus with a bias+100 collector model, a row scoreboard and per-cycle skew expectations
module tb_psum_sequencer;
  localparam int COLS = 4;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int W = COLS*DW;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic [15:0] tile_len = '0;
  logic bin_valid = 0;
  logic res_ready = 0;
  logic [W-1:0] bin_data = '0;
  logic [W-1:0] sout_col, bin_col, res_data;
  logic bin_ready, en_out, res_valid, busy, done;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int dones = 0;
  int done_cyc = 0;
  int ens = 0;
  int s, t, sent, d0, e0;
  logic hs;
  logic [W-1:0] r;
  logic [W-1:0] q[$];
  int pop_cycles[$];
  logic [W-1:0] exp_bin [16];
  logic exp_en [16];
  psum_sequencer #(.COLS(COLS), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .tile_len(tile_len),
    .bin_valid(bin_valid), .bin_ready(bin_ready), .bin_data(bin_data),
    .en_out(en_out), .bin_col(bin_col), .sout_col(sout_col),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always_comb begin
    sout_col = '0;
    for (int k = 0; k < COLS; k++) sout_col[k*DW+:DW] = bin_col[k*DW+:DW] + DW'(100);
  end
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [W-1:0] mkrow(input int i);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < COLS; k++) v[k*DW+:DW] = DW'(i*256 + k*16 + 7);
    return v;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input int len);
    start = 1;
    tile_len = 16'(len);
    tick();
    start = 0;
  endtask
  task automatic send_rows(input string nm, input int n, input int base, input int limit, output int cycles);
    int cnt;
    logic h;
    cnt = 0;
    cycles = 0;
    bin_valid = 1;
    while (cnt < n && cycles < limit) begin
      bin_data = mkrow(base + cnt);
      h = bin_ready;
      tick();
      if (h) cnt++;
      cycles++;
    end
    bin_valid = 0;
    chk({nm, "_sent"}, W'(cnt), W'(n));
  endtask
  task automatic wait_done(input string nm);
    int dd, tt;
    dd = dones;
    tt = 0;
    while (dones == dd && tt < 200) begin
      tick();
      tt++;
    end
    chk(nm, W'(dones != dd), W'(1));
  endtask
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      for (int i = 0; i < 16; i++) begin
        exp_en[i] = 0;
        exp_bin[i] = '0;
      end
      chk("rst_ctrl", W'({bin_ready, en_out, res_valid, busy, done}), '0);
      chk("rst_bin_col", bin_col, '0);
      chk("rst_res_data", res_data, '0);
    end else begin
      s = cyc % 16;
      chk("en_out", W'(en_out), W'(exp_en[s]));
      chk("bin_col", bin_col, exp_bin[s]);
      exp_en[s] = 0;
      exp_bin[s] = '0;
      chk("credit", W'(bin_ready && (q.size() >= DEPTH || !busy)), '0);
      if (res_valid) begin
        chk("res_pending", W'(q.size() > 0), W'(1));
        if (q.size() > 0) begin
          chk("res_data", res_data, q[0]);
          if (res_ready) begin
            void'(q.pop_front());
            pop_cycles.push_back(cyc);
          end
        end
      end
      if (bin_valid && bin_ready) begin
        r = '0;
        for (int k = 0; k < COLS; k++) r[k*DW+:DW] = bin_data[k*DW+:DW] + DW'(100);
        q.push_back(r);
        exp_en[(cyc+1)%16] = 1;
        for (int k = 0; k < COLS; k++) exp_bin[(cyc+1+k)%16][k*DW+:DW] = bin_data[k*DW+:DW];
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (en_out) ens++;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected summary before timeout");
    $fatal(1);
  end
  initial begin
    repeat (2) tick();
    chk("rst_busy", W'(busy), '0);
    rst = 0;
    tick();
    do_start(1);
    bin_data = {32'd4, 32'd3, 32'd2, 32'd1};
    bin_valid = 1;
    chk("t1_ready", W'(bin_ready), W'(1));
    tick();
    bin_valid = 0;
    chk("t1_en_e0", W'(en_out), W'(1));
    chk("t1_col_e0", bin_col, {32'd0, 32'd0, 32'd0, 32'd1});
    tick();
    chk("t1_en_e1", W'(en_out), '0);
    chk("t1_col_e1", bin_col, {32'd0, 32'd0, 32'd2, 32'd0});
    tick();
    chk("t1_col_e2", bin_col, {32'd0, 32'd3, 32'd0, 32'd0});
    tick();
    chk("t1_col_e3", bin_col, {32'd4, 32'd0, 32'd0, 32'd0});
    chk("t1_valid_early", W'(res_valid), '0);
    tick();
    chk("t1_valid", W'(res_valid), W'(1));
    chk("t1_res", res_data, {32'd104, 32'd103, 32'd102, 32'd101});
    chk("t1_col_idle", bin_col, '0);
    res_ready = 1;
    wait_done("t1_done");
    pop_cycles.delete();
    d0 = dones;
    do_start(16);
    send_rows("t2", 16, 100, 40, t);
    chk("t2_ready_continuous", W'(t), W'(16));
    wait_done("t2_done");
    repeat (3) tick();
    chk("t2_done_once", W'(dones - d0), W'(1));
    chk("t2_rows", W'(pop_cycles.size()), W'(16));
    chk("t2_rate", W'(pop_cycles[15] - pop_cycles[0]), W'(15));
    chk("t2_done_time", W'(done_cyc), W'(pop_cycles[15] + 2));
    pop_cycles.delete();
    res_ready = 0;
    do_start(20);
    bin_valid = 1;
    sent = 0;
    repeat (20) begin
      bin_data = mkrow(300 + sent);
      hs = bin_ready;
      tick();
      if (hs) sent++;
    end
    chk("t3_credit_stop", W'(sent), W'(DEPTH));
    chk("t3_ready_low", W'(bin_ready), '0);
    chk("t3_res_held", W'(res_valid), W'(1));
    res_ready = 1;
    send_rows("t3_rest", 12, 308, 100, t);
    wait_done("t3_done");
    chk("t3_rows", W'(pop_cycles.size()), W'(20));
    e0 = ens;
    do_start(0);
    chk("t4_done_s0", W'(done), '0);
    chk("t4_busy", W'(busy), W'(1));
    tick();
    chk("t4_done_s1", W'(done), '0);
    tick();
    chk("t4_done_s2", W'(done), W'(1));
    tick();
    chk("t4_done_s3", W'({done, busy}), '0);
    chk("t4_no_en", W'(ens - e0), '0);
    res_ready = 0;
    do_start(10);
    send_rows("t5", 5, 500, 20, t);
    tick();
    chk("t5_pre_valid", W'(res_valid), W'(1));
    rst = 1;
    #1;
    chk("t5_rst_ctrl", W'({bin_ready, en_out, res_valid, busy, done}), '0);
    chk("t5_rst_col", bin_col, '0);
    chk("t5_rst_data", res_data, '0);
    tick();
    rst = 0;
    tick();
    pop_cycles.delete();
    res_ready = 1;
    do_start(3);
    send_rows("t5_new", 3, 600, 20, t);
    wait_done("t5_done");
    chk("t5_rows", W'(pop_cycles.size()), W'(3));
    pop_cycles.delete();
    do_start(6);
    send_rows("t6a", 3, 700, 20, t);
    start = 1;
    tile_len = 16'd2;
    tick();
    start = 0;
    chk("t6_busy", W'(busy), W'(1));
    send_rows("t6b", 3, 703, 20, t);
    chk("t6_ready_end", W'(bin_ready), '0);
    wait_done("t6_done");
    chk("t6_rows", W'(pop_cycles.size()), W'(6));
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/psum_sequencer.md
# psum_sequencer

Drives the bias/pre-accumulation side of the systolic array's accumulation-collector chain and collects its outputs. It accepts one row of COLS bias words per handshake and issues it to the collector chain: enable into column 0, Bin skewed one cycle per column. It captures each column's accumulation output at the matching skewed cycle, deskews the row, and buffers it in a result FIFO toward the MMU. Credit-based issue guarantees no result is ever dropped, because the array itself cannot be stalled.

## Interface
- COLS, 4, number of collector columns (≥2)
- DW, 32, word width
- DEPTH, 8, result FIFO depth in rows (≥COLS+1)
- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a tile; sampled only in IDLE
- tile_len  in  16  rows in tile, latched on start
- bin_valid  in  1  bias row valid
- bin_ready  out  1  bias row accepted when valid&&ready
- bin_data  in  COLS*DW  bias row, column 0 in LSBs
- en_out  out  1  enable into column-0 collector
- bin_col  out  COLS*DW  per-column Bin, column k at [k*DW+:DW]
- sout_col  in  COLS*DW  per-column accumulation outputs from collectors
- res_valid  out  1  result row valid
- res_ready  in  1  consumer accepts row
- res_data  out  COLS*DW  result row, column 0 in LSBs
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at tile end

## Operation
- FSM: IDLE → RUN on start (latch tile_len, clear issued counter). RUN → DRAIN when issued==tile_len. DRAIN → DONE when inflight==0 and FIFO empty. DONE → IDLE after one cycle, with done=1 in DONE.
- start with tile_len=0: IDLE→RUN→DRAIN→DONE with no handshakes. done pulses 3 cycles after start.
- start while busy is ignored.
- bin_ready = (state==RUN) && (issued<tile_len) && (inflight + fifo_count < DEPTH).
- Issue at handshake edge E:
  - en_out=1 and bin_col[0]=bias[0] during cycle E..E+1.
  - bin_col[k]=bias[k] during cycle E+k..E+k+1, via per-column shift registers.
  - Unoccupied slots drive bin_col=0.
  - en_out=0 unless issuing.
  - inflight increments.
- Capture: sout_col[k] sampled at edge E+k+1 into row assembly slot. Complete row pushed to FIFO at edge E+COLS. inflight decrements at the same edge.
- Back-to-back issue every cycle is legal. Up to COLS rows in flight simultaneously, each tracked by a valid bit in a COLS-deep skew pipeline.
- Simultaneous issue and push in one cycle: inflight unchanged.
- Arithmetic: none in this block. Words pass unmodified; addition/wrap mod 2^DW happens in the collectors.
- FIFO push never occurs when full. The credit rule guarantees this. An assertion flags any violation.
- Reset (any time, including mid-tile) clears:
  - FSM to IDLE
  - counters
  - skew/valid pipelines
  - FIFO
  All in-flight rows are discarded.

## Timing
- Reset values: bin_ready=0, en_out=0, bin_col=0, res_valid=0, res_data=0, busy=0, done=0.
- Latency from bin handshake edge to res_valid (FIFO empty): COLS+1 edges, i.e. res_valid high in cycle after push edge E+COLS.
- FIFO is first-word-fall-through registered output. res_data stable while res_valid && !res_ready.
- Throughput: 1 row/cycle when res_ready held high.
- bin_ready depends only on registered state; no combinational path from bin_valid or res_ready.

## Structure
- Shared package mm_vmx_pkg: DW, COLS defaults, FSM state enum (IDLE, RUN, DRAIN, DONE).
- One sub-module: psum_fifo (synchronous FIFO, width COLS*DW, depth DEPTH, count output, async active-high rst).
- Skew pipeline, capture logic and FSM stay in psum_sequencer.

## Test plan
- COLS=4, tile_len=1, bias words {1,2,3,4}, collector model returns Bin+100:
  - en_out pulse 1 cycle after handshake.
  - bin_col[k]=k+1 exactly at cycle k.
  - res_data {101,102,103,104} valid 5 cycles after handshake.
- tile_len=16, bin_valid and res_ready always 1:
  - bin_ready continuous.
  - 16 results in order, one per cycle.
  - done pulses once after last accept.
- res_ready held 0, tile_len=20, DEPTH=8:
  - bin_ready drops after 8 issues.
  - FIFO full, no overflow assertion.
  - Releasing res_ready yields all 20 rows in order.
- tile_len=0 → done pulses 3 cycles after start. en_out never asserted.
- rst asserted with 3 rows in flight and 2 in FIFO:
  - All outputs return to reset values immediately.
  - A new tile then runs with no stale results.
- start pulsed during RUN → ignored; tile_len unchanged, issued count continues.
